// File: rtl/pwm_preconditioner_pkg.sv
// Shared constants for the PWM preconditioner: tick-period width, input widths
// and the pulse-width ceiling.
package pwm_preconditioner_pkg;

  localparam int TICK_W  = 9;   // 512-tick ultrasound period
  localparam int PW_W    = 9;
  localparam int PHASE_W = 8;

  localparam logic [PW_W-1:0] MAX_PW = PW_W'(256);

  function automatic logic [PW_W-1:0] clamp_pw(input logic [PW_W-1:0] pw);
    return (pw > MAX_PW) ? MAX_PW : pw;
  endfunction

endpackage

// File: rtl/pwm_preconditioner_edge_calc.sv
// Combinational edge placement: centres a pulse of width PW on tick 2*PHASE,
// with floor(PW/2) before the centre and ceil(PW/2) after it, modulo 512.
module pwm_edge_calc
  import pwm_preconditioner_pkg::*;
(
  input  logic [PW_W-1:0]    pw,
  input  logic [PHASE_W-1:0] phase,
  output logic [TICK_W-1:0]  rise,
  output logic [TICK_W-1:0]  fall
);

  logic [PW_W-1:0] pw_c;
  logic [TICK_W:0] base;
  logic [TICK_W:0] half_lo;
  logic [TICK_W:0] half_hi;

  always_comb begin
    pw_c    = clamp_pw(pw);
    base    = {1'b0, phase, 1'b0};
    half_lo = {2'b00, pw_c[PW_W-1:1]};
    // ceil half keeps fall - rise == PW exactly, including odd widths
    half_hi = {1'b0, pw_c} - half_lo;
    rise    = TICK_W'(base - half_lo);
    fall    = TICK_W'(base + half_hi);
  end

endmodule

// File: rtl/pwm_preconditioner.sv
// Collects one frame of per-transducer PWM edges into a shadow buffer and
// commits it to the outputs atomically on the ultrasound-period UPDATE strobe.
module pwm_preconditioner
  import pwm_preconditioner_pkg::*;
#(
  parameter int DEPTH = 249
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                UPDATE,
  input  logic                DIN_VALID,
  input  logic [PW_W-1:0]     PULSE_WIDTH_IN,
  input  logic [PHASE_W-1:0]  PHASE_IN,
  output logic [TICK_W-1:0]   RISE [DEPTH],
  output logic [TICK_W-1:0]   FALL [DEPTH],
  output logic                FRAME_DONE
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // Input stream is valid-only (no ready): every cycle with DIN_VALID high
  // delivers exactly one entry, in index order; low cycles are ignored.
  logic [TICK_W-1:0] calc_rise, calc_fall;
  logic [IDX_W-1:0]  index_q;
  logic [IDX_W-1:0]  pipe_idx_q;
  logic              pipe_valid_q;
  logic [TICK_W-1:0] pipe_rise_q, pipe_fall_q;
  logic              pending_q;
  logic              last_write;

  logic [TICK_W-1:0] fill_rise   [DEPTH];
  logic [TICK_W-1:0] fill_fall   [DEPTH];
  logic [TICK_W-1:0] shadow_rise [DEPTH];
  logic [TICK_W-1:0] shadow_fall [DEPTH];

  pwm_edge_calc u_edge_calc (
    .pw    (PULSE_WIDTH_IN),
    .phase (PHASE_IN),
    .rise  (calc_rise),
    .fall  (calc_fall)
  );

  assign last_write = pipe_valid_q && (pipe_idx_q == LAST_IDX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      index_q      <= '0;
      pipe_idx_q   <= '0;
      pipe_valid_q <= 1'b0;
      pipe_rise_q  <= '0;
      pipe_fall_q  <= '0;
      pending_q    <= 1'b0;
      FRAME_DONE   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        RISE[i] <= '0;
        FALL[i] <= '0;
      end
    end else begin
      pipe_valid_q <= DIN_VALID;
      if (DIN_VALID) begin
        pipe_idx_q  <= index_q;
        pipe_rise_q <= calc_rise;
        pipe_fall_q <= calc_fall;
        index_q     <= (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
      end
      FRAME_DONE <= last_write;
      // A commit uses the shadow as it stood before this edge, so a frame
      // completing on the same edge waits for the next UPDATE.
      if (UPDATE && pending_q) begin
        for (int i = 0; i < DEPTH; i++) begin
          RISE[i] <= shadow_rise[i];
          FALL[i] <= shadow_fall[i];
        end
      end
      if (last_write) begin
        pending_q <= 1'b1;
      end else if (UPDATE && pending_q) begin
        pending_q <= 1'b0;
      end
    end
  end

  // Entries land in the fill buffer; the shadow only ever holds complete
  // frames, so a frame still arriving can never leak into a commit.
  always_ff @(posedge CLK) begin
    if (pipe_valid_q) begin
      fill_rise[pipe_idx_q] <= pipe_rise_q;
      fill_fall[pipe_idx_q] <= pipe_fall_q;
    end
    if (last_write) begin
      for (int i = 0; i < DEPTH; i++) begin
        shadow_rise[i] <= (i == DEPTH - 1) ? pipe_rise_q : fill_rise[i];
        shadow_fall[i] <= (i == DEPTH - 1) ? pipe_fall_q : fill_fall[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_preconditioner.sv
// Directed bench for pwm_preconditioner: hand-computed edge values, frame
// commit rules, UPDATE coincidence, back-to-back frames and mid-burst reset.
`timescale 1ns/1ps
module tb_pwm_preconditioner;

  localparam int DEPTH = 249;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       UPDATE = 1'b0;
  logic       DIN_VALID = 1'b0;
  logic [8:0] PULSE_WIDTH_IN = '0;
  logic [7:0] PHASE_IN = '0;
  logic [8:0] RISE [DEPTH];
  logic [8:0] FALL [DEPTH];
  logic       FRAME_DONE;

  int n_checks = 0;
  int n_errors = 0;
  int fd_count = 0;

  // {rise, fall} per entry
  logic [17:0] exp_q[$];
  logic [17:0] shadow_m [DEPTH];
  logic [17:0] out_m    [DEPTH];
  logic [8:0]  frame_pw [DEPTH];
  logic [7:0]  frame_ph [DEPTH];

  pwm_preconditioner #(.DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .UPDATE         (UPDATE),
    .DIN_VALID      (DIN_VALID),
    .PULSE_WIDTH_IN (PULSE_WIDTH_IN),
    .PHASE_IN       (PHASE_IN),
    .RISE           (RISE),
    .FALL           (FALL),
    .FRAME_DONE     (FRAME_DONE)
  );

  // clock / reset
  always #24 CLK = ~CLK;

  always @(negedge CLK) begin
    if (FRAME_DONE === 1'b1) fd_count++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] model_edges(input int pw, input int ph);
    int p, r, f;
    logic [17:0] res;
    p = (pw > 256) ? 256 : pw;
    r = 2 * ph - p / 2;
    f = 2 * ph + (p + 1) / 2;
    r = ((r % 512) + 512) % 512;
    f = f % 512;
    res = {r[8:0], f[8:0]};
    return res;
  endfunction

  // driver tasks
  task automatic send_entry(input logic [8:0] pw, input logic [7:0] ph);
    DIN_VALID = 1'b1;
    PULSE_WIDTH_IN = pw;
    PHASE_IN = ph;
    @(posedge CLK); #1;
    DIN_VALID = 1'b0;
    PULSE_WIDTH_IN = 9'($urandom_range(0, 511));
    PHASE_IN = 8'($urandom_range(0, 255));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic gen_random_frame();
    for (int k = 0; k < DEPTH; k++) begin
      frame_pw[k] = 9'($urandom_range(0, 511));
      frame_ph[k] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic send_frame(input int gaps, input int count);
    exp_q.delete();
    for (int k = 0; k < count; k++) begin
      if ((gaps >= 1 && k == 60) || (gaps >= 2 && k == 130) || (gaps >= 3 && k == 200))
        idle(1);
      send_entry(frame_pw[k], frame_ph[k]);
      exp_q.push_back(model_edges(int'(frame_pw[k]), int'(frame_ph[k])));
    end
    if (count == DEPTH) begin
      for (int k = 0; k < DEPTH; k++) shadow_m[k] = exp_q[k];
    end
  endtask

  task automatic pulse_update();
    UPDATE = 1'b1;
    @(posedge CLK); #1;
    UPDATE = 1'b0;
  endtask

  task automatic commit_model();
    for (int k = 0; k < DEPTH; k++) out_m[k] = shadow_m[k];
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < DEPTH; k++) begin
      check({tag, "_rise"}, int'(RISE[k]), int'(out_m[k][17:9]));
      check({tag, "_fall"}, int'(FALL[k]), int'(out_m[k][8:0]));
    end
  endtask

  task automatic wait_settle();
    repeat (3) @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) out_m[k] = '0;
    #1 RST = 1'b1;
    #60;
    check_outputs("reset");
    check("reset_frame_done", int'(FRAME_DONE), 0);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;

    // directed frame: hand-computed edges in entries 0..4
    gen_random_frame();
    frame_pw[0] = 9'd0;   frame_ph[0] = 8'd0;
    frame_pw[1] = 9'd256; frame_ph[1] = 8'd0;
    frame_pw[2] = 9'd1;   frame_ph[2] = 8'd255;
    frame_pw[3] = 9'd255; frame_ph[3] = 8'd128;
    frame_pw[4] = 9'd300; frame_ph[4] = 8'd0;
    send_frame(0, DEPTH);
    wait_settle();
    check("frame_done_a", fd_count, 1);
    check_outputs("pre_update");
    pulse_update();
    commit_model();
    check("pw0_rise", int'(RISE[0]), 0);
    check("pw0_fall", int'(FALL[0]), 0);
    check("pw256_rise", int'(RISE[1]), 384);
    check("pw256_fall", int'(FALL[1]), 128);
    check("ph255_rise", int'(RISE[2]), 510);
    check("ph255_fall", int'(FALL[2]), 511);
    check("ph128_rise", int'(RISE[3]), 129);
    check("ph128_fall", int'(FALL[3]), 384);
    check("clamp_rise", int'(RISE[4]), 384);
    check("clamp_fall", int'(FALL[4]), 128);
    check_outputs("frame_a");

    // UPDATE with nothing pending holds outputs
    pulse_update();
    check_outputs("no_pending");

    // random frame with three DIN_VALID gaps
    gen_random_frame();
    send_frame(3, DEPTH);
    wait_settle();
    check("frame_done_gaps", fd_count, 2);
    check_outputs("gap_hold");
    pulse_update();
    commit_model();
    check_outputs("gap_frame");

    // UPDATE on the same edge as the final shadow write
    gen_random_frame();
    send_frame(0, DEPTH);
    UPDATE = 1'b1;
    @(posedge CLK); #1;
    UPDATE = 1'b0;
    check_outputs("coincident_hold");
    wait_settle();
    check("frame_done_coinc", fd_count, 3);
    check_outputs("coincident_still");
    pulse_update();
    commit_model();
    check_outputs("coincident_commit");

    // two back-to-back frames, one UPDATE: second frame wins
    gen_random_frame();
    send_frame(0, DEPTH);
    gen_random_frame();
    send_frame(0, DEPTH);
    wait_settle();
    check("frame_done_b2b", fd_count, 5);
    check_outputs("b2b_hold");
    pulse_update();
    commit_model();
    check_outputs("b2b_second");

    // reset in the middle of a burst
    gen_random_frame();
    send_frame(0, 101);
    #5 RST = 1'b1;
    #10;
    for (int k = 0; k < DEPTH; k++) out_m[k] = '0;
    check_outputs("rst_mid");
    check("rst_mid_frame_done", int'(FRAME_DONE), 0);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    pulse_update();
    check_outputs("rst_no_commit");
    gen_random_frame();
    send_frame(0, DEPTH);
    wait_settle();
    check("frame_done_rst", fd_count, 6);
    pulse_update();
    commit_model();
    check_outputs("rst_fresh");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
